gshare_predictor: RTL and testbench



---
 rtl/gshare_predictor.sv | 167 ++++++++++++++++
 tb/tb_gshare_predictor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: PC^GHR-indexed saturating-counter PHT plus a tagged JALR BTB.
// One registered prediction per accepted fetch request; GHR restored on ROB flush.
module gshare_predictor #(
    parameter int PHT_IDX_W = 9,
    parameter int CTR_W     = 2,
    parameter int GHR_W     = 8,
    parameter int BTB_IDX_W = 6,
    parameter int BTB_TAG_W = 8,
    parameter int ADDR_W    = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_valid,
    input  logic [31:0]       req_pc,
    input  logic [31:0]       req_inst,
    output logic              resp_valid,
    output logic [31:0]       pred_pc,
    output logic              pred_taken,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              train_valid,
    input  logic [31:0]       train_pc,
    input  logic              train_is_jalr,
    input  logic              train_taken,
    input  logic [GHR_W-1:0]  train_ghr,
    input  logic [31:0]       train_target,
    input  logic              flush,
    input  logic [GHR_W-1:0]  flush_ghr
);

    localparam int unsigned PHT_N = 1 << PHT_IDX_W;
    localparam int unsigned BTB_N = 1 << BTB_IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [31:0] PC_MASK = 32'((64'd1 << ADDR_W) - 64'd1);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [CTR_W-1:0]     pht        [PHT_N];
    logic                 btb_valid  [BTB_N];
    logic [BTB_TAG_W-1:0] btb_tag    [BTB_N];
    logic [31:0]          btb_target [BTB_N];
    logic [GHR_W-1:0]     ghr;

    logic [PHT_IDX_W-1:0] req_hist;
    logic [PHT_IDX_W-1:0] train_hist;

    // History folding: truncate when GHR is wide enough, zero-extend otherwise.
    generate
        if (GHR_W >= PHT_IDX_W) begin : g_fold_trunc
            assign req_hist   = ghr[PHT_IDX_W-1:0];
            assign train_hist = train_ghr[PHT_IDX_W-1:0];
        end else begin : g_fold_ext
            assign req_hist   = {{(PHT_IDX_W-GHR_W){1'b0}}, ghr};
            assign train_hist = {{(PHT_IDX_W-GHR_W){1'b0}}, train_ghr};
        end
    endgenerate

    logic                 req_accept;
    logic [6:0]           opcode;
    logic [31:0]          imm_b;
    logic [31:0]          imm_j;
    logic [PHT_IDX_W-1:0] req_pht_idx;
    logic [BTB_IDX_W-1:0] req_btb_idx;
    logic [BTB_TAG_W-1:0] req_tag;
    logic                 btb_hit;
    logic [31:0]          next_pc;
    logic                 next_taken;
    logic                 is_branch;

    always_comb begin
        req_accept  = rdy && req_valid && !flush;
        opcode      = req_inst[6:0];
        imm_b       = {{19{req_inst[31]}}, req_inst[31], req_inst[7],
                       req_inst[30:25], req_inst[11:8], 1'b0};
        imm_j       = {{11{req_inst[31]}}, req_inst[31], req_inst[19:12],
                       req_inst[20], req_inst[30:21], 1'b0};
        req_pht_idx = req_pc[PHT_IDX_W+1:2] ^ req_hist;
        req_btb_idx = req_pc[BTB_IDX_W+1:2];
        req_tag     = req_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
        btb_hit     = btb_valid[req_btb_idx] && (btb_tag[req_btb_idx] == req_tag);
        next_pc     = req_pc + 32'd4;
        next_taken  = 1'b0;
        is_branch   = 1'b0;
        case (opcode)
            OP_BRANCH: begin
                is_branch = 1'b1;
                if (pht[req_pht_idx][CTR_W-1]) begin
                    next_pc    = req_pc + imm_b;
                    next_taken = 1'b1;
                end
            end
            OP_JAL: begin
                next_pc    = req_pc + imm_j;
                next_taken = 1'b1;
            end
            OP_JALR: begin
                if (btb_hit) begin
                    next_pc    = btb_target[req_btb_idx];
                    next_taken = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic [PHT_IDX_W-1:0] train_pht_idx;
    logic [BTB_IDX_W-1:0] train_btb_idx;
    logic [BTB_TAG_W-1:0] train_tag;
    logic [CTR_W-1:0]     train_ctr;
    logic [CTR_W-1:0]     ctr_next;

    always_comb begin
        train_pht_idx = train_pc[PHT_IDX_W+1:2] ^ train_hist;
        train_btb_idx = train_pc[BTB_IDX_W+1:2];
        train_tag     = train_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
        train_ctr     = pht[train_pht_idx];
        ctr_next      = train_ctr;
        if (train_taken) begin
            if (train_ctr != '1) ctr_next = train_ctr + CTR_W'(1);
        end else begin
            if (train_ctr != '0) ctr_next = train_ctr - CTR_W'(1);
        end
    end

    logic unused_train_pc;
    assign unused_train_pc = ^train_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHT_N; i++) pht[i] <= CTR_INIT;
            for (int unsigned i = 0; i < BTB_N; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
            ghr        <= '0;
            resp_valid <= 1'b0;
            pred_pc    <= '0;
            pred_taken <= 1'b0;
            pred_ghr   <= '0;
        end else if (rdy) begin
            resp_valid <= req_accept;
            if (req_accept) begin
                pred_pc    <= next_pc & PC_MASK;
                pred_taken <= next_taken;
                pred_ghr   <= ghr;
            end
            // Flush wins over the speculative shift of a (dropped) same-cycle request.
            if (flush)
                ghr <= flush_ghr;
            else if (req_accept && is_branch)
                ghr <= {ghr[GHR_W-2:0], next_taken};
            if (train_valid) begin
                if (train_is_jalr) begin
                    btb_valid[train_btb_idx]  <= 1'b1;
                    btb_tag[train_btb_idx]    <= train_tag;
                    btb_target[train_btb_idx] <= train_target;
                end else begin
                    pht[train_pht_idx] <= ctr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor with hand-computed expectations.
module tb_gshare_predictor;

    localparam logic [31:0] BEQ8  = 32'h00000463;
    localparam logic [31:0] JAL16 = 32'h0100006f;
    localparam logic [31:0] JALR  = 32'h00008067;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, rdy, req_valid, train_valid, train_is_jalr, train_taken, flush;
    logic [31:0] req_pc, req_inst, train_pc, train_target, pred_pc;
    logic [7:0]  train_ghr, flush_ghr, pred_ghr;
    logic        resp_valid, pred_taken;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gshare_predictor #(.PHT_IDX_W(9), .CTR_W(2), .GHR_W(8), .BTB_IDX_W(6),
                       .BTB_TAG_W(8), .ADDR_W(17)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_pc(req_pc),
        .req_inst(req_inst), .resp_valid(resp_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_ghr(pred_ghr), .train_valid(train_valid),
        .train_pc(train_pc), .train_is_jalr(train_is_jalr), .train_taken(train_taken),
        .train_ghr(train_ghr), .train_target(train_target), .flush(flush),
        .flush_ghr(flush_ghr)
    );

    // All tasks start and end just after a negedge; outputs are stable there.
    task automatic do_req(input logic [31:0] pc, input logic [31:0] inst);
        req_valid = 1'b1; req_pc = pc; req_inst = inst;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_train(input logic [31:0] pc, input logic jalr, input logic tk,
                            input logic [7:0] g, input logic [31:0] tgt);
        train_valid = 1'b1; train_pc = pc; train_is_jalr = jalr;
        train_taken = tk; train_ghr = g; train_target = tgt;
        @(negedge clk);
        train_valid = 1'b0;
    endtask

    task automatic do_flush(input logic [7:0] g);
        flush = 1'b1; flush_ghr = g;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset;
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b exp 0", resp_valid); end
        tests++; if (pred_pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp 0", pred_pc); end
        tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL rst_taken got %0b exp 0", pred_taken); end
        tests++; if (pred_ghr !== 8'h00) begin fails++; $display("FAIL rst_ghr got %h exp 00", pred_ghr); end
    endtask

    task automatic test_branch;
        do_req(32'h100, BEQ8);
        tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL br_valid got %0b exp 1", resp_valid); end
        tests++; if (pred_pc !== 32'h104) begin fails++; $display("FAIL br_nt_pc got %h exp 104", pred_pc); end
        tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL br_nt_taken got %0b exp 0", pred_taken); end
        tests++; if (pred_ghr !== 8'h00) begin fails++; $display("FAIL br_nt_ghr got %h exp 00", pred_ghr); end
        @(negedge clk);
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL br_pulse got %0b exp 0", resp_valid); end
        do_req(32'h500, NOP);
        tests++; if (pred_ghr !== 8'h00) begin fails++; $display("FAIL br_ghr_hold got %h exp 00", pred_ghr); end
        do_train(32'h100, 1'b0, 1'b1, 8'h00, 32'h0);
        do_train(32'h100, 1'b0, 1'b1, 8'h00, 32'h0);
        do_req(32'h100, BEQ8);
        tests++; if (pred_pc !== 32'h108) begin fails++; $display("FAIL br_tk_pc got %h exp 108", pred_pc); end
        tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL br_tk_taken got %0b exp 1", pred_taken); end
        tests++; if (pred_ghr !== 8'h00) begin fails++; $display("FAIL br_tk_ghr got %h exp 00", pred_ghr); end
        do_req(32'h500, NOP);
        tests++; if (pred_ghr !== 8'h01) begin fails++; $display("FAIL br_ghr_shift got %h exp 01", pred_ghr); end
        tests++; if (pred_pc !== 32'h504) begin fails++; $display("FAIL nop_pc got %h exp 504", pred_pc); end
    endtask

    task automatic test_saturate;
        do_flush(8'h00);
        repeat (4) do_train(32'h100, 1'b0, 1'b0, 8'h00, 32'h0);
        do_train(32'h100, 1'b0, 1'b1, 8'h00, 32'h0);
        do_req(32'h100, BEQ8);
        tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL sat_lo_01 got %0b exp 0", pred_taken); end
        do_train(32'h100, 1'b0, 1'b1, 8'h00, 32'h0);
        do_req(32'h100, BEQ8);
        tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL sat_lo_10 got %0b exp 1", pred_taken); end
        do_flush(8'h00);
        repeat (2) do_train(32'h100, 1'b0, 1'b1, 8'h00, 32'h0);
        repeat (2) do_train(32'h100, 1'b0, 1'b0, 8'h00, 32'h0);
        do_req(32'h100, BEQ8);
        tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL sat_hi got %0b exp 0", pred_taken); end
        tests++; if (pred_pc !== 32'h104) begin fails++; $display("FAIL sat_hi_pc got %h exp 104", pred_pc); end
    endtask

    task automatic test_jal;
        do_flush(8'h5A);
        do_req(32'h200, JAL16);
        tests++; if (pred_pc !== 32'h210) begin fails++; $display("FAIL jal_pc got %h exp 210", pred_pc); end
        tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL jal_taken got %0b exp 1", pred_taken); end
        tests++; if (pred_ghr !== 8'h5A) begin fails++; $display("FAIL jal_ghr got %h exp 5a", pred_ghr); end
        do_req(32'h500, NOP);
        tests++; if (pred_ghr !== 8'h5A) begin fails++; $display("FAIL jal_ghr_hold got %h exp 5a", pred_ghr); end
    endtask

    task automatic test_jalr;
        do_req(32'h300, JALR);
        tests++; if (pred_pc !== 32'h304 || pred_taken !== 1'b0) begin fails++; $display("FAIL jalr_miss got %h/%0b exp 304/0", pred_pc, pred_taken); end
        do_train(32'h300, 1'b1, 1'b0, 8'h00, 32'h1234);
        do_req(32'h300, JALR);
        tests++; if (pred_pc !== 32'h1234 || pred_taken !== 1'b1) begin fails++; $display("FAIL jalr_hit got %h/%0b exp 1234/1", pred_pc, pred_taken); end
        do_req(32'h4300, JALR);
        tests++; if (pred_pc !== 32'h4304 || pred_taken !== 1'b0) begin fails++; $display("FAIL jalr_tag got %h/%0b exp 4304/0", pred_pc, pred_taken); end
    endtask

    task automatic test_back_to_back;
        // Same-cycle train and lookup of one BTB entry: lookup sees the old entry.
        train_valid = 1'b1; train_pc = 32'h380; train_is_jalr = 1'b1;
        train_taken = 1'b0; train_ghr = 8'h00; train_target = 32'h2000;
        do_req(32'h380, JALR);
        train_valid = 1'b0;
        tests++; if (pred_pc !== 32'h384) begin fails++; $display("FAIL rbw_pc got %h exp 384", pred_pc); end
        do_req(32'h380, JALR);
        tests++; if (pred_pc !== 32'h2000) begin fails++; $display("FAIL rbw_after got %h exp 2000", pred_pc); end
        tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got %0b exp 1", resp_valid); end
    endtask

    task automatic test_wrap;
        do_flush(8'h00);
        repeat (2) do_train(32'h1FFFC, 1'b0, 1'b1, 8'h00, 32'h0);
        do_req(32'h1FFFC, BEQ8);
        tests++; if (pred_pc !== 32'h00004) begin fails++; $display("FAIL wrap_pc got %h exp 4", pred_pc); end
        tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL wrap_taken got %0b exp 1", pred_taken); end
    endtask

    task automatic test_flush;
        flush = 1'b1; flush_ghr = 8'hA5;
        do_req(32'h100, BEQ8);
        flush = 1'b0;
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL flush_drop got %0b exp 0", resp_valid); end
        do_req(32'h500, NOP);
        tests++; if (pred_ghr !== 8'hA5) begin fails++; $display("FAIL flush_ghr got %h exp a5", pred_ghr); end
    endtask

    task automatic test_rdy;
        rdy = 1'b0;
        req_valid = 1'b1; req_pc = 32'h100; req_inst = JAL16;
        train_valid = 1'b1; train_pc = 32'h300; train_is_jalr = 1'b1; train_target = 32'h9999;
        flush = 1'b1; flush_ghr = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (resp_valid !== 1'b1 || pred_pc !== 32'h504 || pred_taken !== 1'b0 || pred_ghr !== 8'hA5) begin
                fails++; $display("FAIL rdy_hold cyc %0d got %0b/%h/%0b/%h exp 1/504/0/a5", i, resp_valid, pred_pc, pred_taken, pred_ghr);
            end
        end
        rdy = 1'b1; req_valid = 1'b0; train_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rdy_release got %0b exp 0", resp_valid); end
        do_req(32'h300, JALR);
        tests++; if (pred_pc !== 32'h1234) begin fails++; $display("FAIL rdy_btb got %h exp 1234", pred_pc); end
        do_req(32'h500, NOP);
        tests++; if (pred_ghr !== 8'hA5) begin fails++; $display("FAIL rdy_ghr got %h exp a5", pred_ghr); end
    endtask

    task automatic test_rst_mid;
        do_flush(8'h00);
        repeat (2) do_train(32'h100, 1'b0, 1'b1, 8'h00, 32'h0);
        do_req(32'h100, BEQ8);
        tests++; if (resp_valid !== 1'b1 || pred_pc !== 32'h108) begin fails++; $display("FAIL rst_pre got %0b/%h exp 1/108", resp_valid, pred_pc); end
        rst = 1'b1;
        #1;
        tests++; if (resp_valid !== 1'b0 || pred_pc !== 32'h0) begin fails++; $display("FAIL rst_async got %0b/%h exp 0/0", resp_valid, pred_pc); end
        @(negedge clk);
        rst = 1'b0;
        do_req(32'h100, BEQ8);
        tests++; if (pred_pc !== 32'h104 || pred_taken !== 1'b0 || pred_ghr !== 8'h00) begin fails++; $display("FAIL rst_pht got %h/%0b/%h exp 104/0/00", pred_pc, pred_taken, pred_ghr); end
        do_req(32'h300, JALR);
        tests++; if (pred_pc !== 32'h304) begin fails++; $display("FAIL rst_btb got %h exp 304", pred_pc); end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; req_valid = 1'b0; req_pc = '0; req_inst = '0;
        train_valid = 1'b0; train_pc = '0; train_is_jalr = 1'b0; train_taken = 1'b0;
        train_ghr = '0; train_target = '0; flush = 1'b0; flush_ghr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_branch;
        test_saturate;
        test_jal;
        test_jalr;
        test_back_to_back;
        test_wrap;
        test_flush;
        test_rdy;
        test_rst_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
